// File: rtl/uart_telemetry_fsm.sv
// uart_telemetry_fsm: snapshots NUM_CH channel words and sends them as an 8N1 frame
// (header, MSB-first zero-extended payload bytes, mod-256 payload checksum).
module uart_telemetry_fsm #(
    parameter int         CLK_FREQ_HZ = 125_000_000,
    parameter int         BAUD        = 115_200,
    parameter int         NUM_CH      = 4,
    parameter int         CH_WIDTH    = 16,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         GAP_BITS    = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fsm_en,
    input  logic                       mode,
    input  logic                       start,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    output logic                       busy,
    output logic                       byte_done,
    output logic                       frame_done,
    output logic                       serial_tx
);
    localparam int CPB      = CLK_FREQ_HZ / BAUD;
    localparam int BPC      = (CH_WIDTH + 7) / 8;
    localparam int PW       = BPC * 8;
    localparam int NPAY     = NUM_CH * BPC;
    localparam int IW       = NPAY > 1 ? $clog2(NPAY) : 1;
    localparam int GAP_CLKS = GAP_BITS * CPB;
    localparam int CW       = GAP_CLKS > 1 ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, GAP} frame_t;
    typedef enum logic [1:0] {START, DATA, STOP} bit_t;

    frame_t          state, state_d;
    bit_t            phase, phase_d;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [IW-1:0]   byte_idx;
    logic [7:0]      shreg, csum, nxt_byte;
    logic [7:0]      pay_in [NPAY];
    logic [7:0]      snap   [NPAY];
    logic            in_byte, bit_end, byte_end, gap_end, last_pay, accept;

    // payload byte order: channel by channel, most significant byte first
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] w;
        assign w = PW'(ch_data[c*CH_WIDTH +: CH_WIDTH]);
        for (genvar k = 0; k < BPC; k++) begin : g_b
            assign pay_in[c*BPC+k] = w[(BPC-1-k)*8 +: 8];
        end
    end

    assign in_byte    = state inside {HDR, PAYLOAD, CSUM};
    assign bit_end    = in_byte && cnt == CW'(CPB - 1);
    assign byte_end   = bit_end && phase == STOP;
    assign gap_end    = state == GAP && cnt == CW'(GAP_CLKS - 1);
    assign last_pay   = byte_idx == IW'(NPAY - 1);
    // the end of GAP doubles as the idle decision so frames are exactly GAP_BITS apart
    assign accept     = (state == IDLE || gap_end) && fsm_en && (!mode || start);
    assign nxt_byte   = state == HDR ? snap[0] : snap[last_pay ? '0 : byte_idx + 1'b1];
    assign busy       = state != IDLE;
    assign byte_done  = byte_end;
    assign frame_done = byte_end && state == CSUM;
    assign serial_tx  = !in_byte || phase == STOP || (phase == DATA && shreg[0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            phase <= START;
        end else begin
            state <= state_d;
            phase <= phase_d;
        end
    end

    always_comb begin
        state_d = state;
        phase_d = phase;
        if (accept) begin
            state_d = HDR;
            phase_d = START;
        end else begin
            case (state)
                HDR:     if (byte_end) state_d = PAYLOAD;
                PAYLOAD: if (byte_end && last_pay) state_d = CSUM;
                CSUM:    if (byte_end) state_d = mode ? IDLE : GAP;
                GAP:     if (gap_end) state_d = IDLE;
                default: ;
            endcase
            if (bit_end)
                phase_d = phase == START ? DATA : phase == STOP ? START : bit_idx == 3'd7 ? STOP : DATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            csum     <= '0;
            for (int i = 0; i < NPAY; i++) snap[i] <= '0;
        end else if (accept) begin
            snap     <= pay_in;
            shreg    <= HEADER;
            csum     <= '0;
            byte_idx <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
        end else begin
            cnt <= (bit_end || gap_end || !(in_byte || state == GAP)) ? '0 : cnt + 1'b1;
            if (bit_end && phase == DATA) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
            if (byte_end && state != CSUM) begin
                shreg <= (state == PAYLOAD && last_pay) ? csum : nxt_byte;
                if (!(state == PAYLOAD && last_pay)) csum <= csum + nxt_byte;
                if (state == PAYLOAD && !last_pay) byte_idx <= byte_idx + 1'b1;
            end
        end
    end
endmodule
